// File: rtl/lock_pc_bank_pkg.sv
// Shared types and default debug credentials for the lockable counter bank
// and its debug-authentication sub-module.
package lock_pc_bank_pkg;

    typedef enum logic [1:0] {
        DBG_IDLE,
        DBG_CHECK,
        DBG_UNLOCKED,
        DBG_PENALTY
    } dbg_state_e;

    localparam logic [31:0] DBG_KEY_DEFAULT = 32'hA5A5_5A5A;
    localparam int          DBG_WIN_DEFAULT = 16;

endpackage

// File: rtl/lock_dbg_auth.sv
// Debug-unlock FSM: captures a key on request, then grants a bounded unlock
// window on a match or imposes an equally long penalty on a mismatch.
module lock_dbg_auth
    import lock_pc_bank_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter logic [31:0] DBG_KEY = DBG_KEY_DEFAULT,
    parameter int          DBG_WIN = DBG_WIN_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              scan,
    input  logic              debug_req,
    input  logic [DATA_W-1:0] debug_key,
    output logic              debug_unlocked
);

    localparam int                CNT_W = $clog2(DBG_WIN + 1);
    localparam logic [DATA_W-1:0] KEY   = DATA_W'(DBG_KEY);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DBG_WIN - 1);

    dbg_state_e        state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [DATA_W-1:0] key_q, key_next;
    logic              rearm_wait, rearm_wait_next;

    // NOTE: non-blocking (<=) so every flop samples pre-edge values in parallel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= DBG_IDLE;
            cnt        <= '0;
            key_q      <= '0;
            rearm_wait <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            key_q      <= key_next;
            rearm_wait <= rearm_wait_next;
        end
    end

    // NOTE: every target gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        key_next        = key_q;
        rearm_wait_next = rearm_wait & debug_req;

        unique case (state)
            DBG_IDLE: begin
                cnt_next = '0;
                if (debug_req && !rearm_wait) begin
                    state_next = DBG_CHECK;
                    key_next   = debug_key;
                end
            end
            DBG_CHECK: begin
                cnt_next   = '0;
                state_next = (key_q == KEY) ? DBG_UNLOCKED : DBG_PENALTY;
            end
            DBG_UNLOCKED: begin
                if (!debug_req) begin
                    state_next = DBG_IDLE;
                end else if (cnt == LAST) begin
                    // Window ran out under a held request: insist on a fresh edge.
                    state_next      = DBG_IDLE;
                    rearm_wait_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DBG_PENALTY: begin
                if (cnt == LAST) begin
                    state_next = DBG_IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = DBG_IDLE;
        endcase

        if (scan) begin
            state_next = DBG_IDLE;
            cnt_next   = '0;
        end
    end

    always_comb begin
        debug_unlocked = (state == DBG_UNLOCKED);
    end

endmodule

// File: rtl/lock_pc_bank.sv
// Bank of auto-incrementing, write-lockable counter channels. Defining
// LOCK_PC_BANK_DEBUG_UNLOCK_EN adds a key-authenticated debug override of the locks.
module lock_pc_bank
    import lock_pc_bank_pkg::*;
#(
    parameter int          NUM_CH  = 4,
    parameter int          DATA_W  = 32,
    parameter int          INC     = 4,
    parameter logic [31:0] DBG_KEY = DBG_KEY_DEFAULT,
    parameter int          DBG_WIN = DBG_WIN_DEFAULT
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       wr_ni,
    input  logic [$clog2(NUM_CH)-1:0]  wr_ch,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NUM_CH-1:0]          lock_set,
    input  logic                       count_en,
    input  logic                       scan,
    input  logic                       debug_req,
    input  logic [DATA_W-1:0]          debug_key,
    output logic [NUM_CH*DATA_W-1:0]   pc_out,
    output logic [NUM_CH-1:0]          lock_status,
    output logic                       debug_unlocked,
    output logic                       wr_err
);

    localparam int                CH_W = $clog2(NUM_CH);
    localparam logic [DATA_W-1:0] STEP = DATA_W'(INC);

    logic [DATA_W-1:0] pc [NUM_CH];
    logic [NUM_CH-1:0] lock;
    logic [NUM_CH-1:0] wr_hit;
    logic              wr_rej;
    logic              unlocked;

`ifdef LOCK_PC_BANK_DEBUG_UNLOCK_EN
    lock_dbg_auth #(
        .DATA_W  (DATA_W),
        .DBG_KEY (DBG_KEY),
        .DBG_WIN (DBG_WIN)
    ) u_dbg_auth (
        .clk            (clk),
        .resetn         (resetn),
        .scan           (scan),
        .debug_req      (debug_req),
        .debug_key      (debug_key),
        .debug_unlocked (unlocked)
    );
`else
    logic unused_dbg;
    assign unused_dbg = ^{debug_req, debug_key, DBG_KEY, 32'(DBG_WIN)};
    assign unlocked   = 1'b0;
`endif

    // Out-of-range channel codes match no channel and fall through to a reject.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!wr_ni && !scan && wr_ch == CH_W'(i) && (!lock[i] || unlocked))
                wr_hit[i] = 1'b1;
        end
        wr_rej = !wr_ni && (wr_hit == '0);
    end

    // NOTE: pc is a small flop bank rather than a RAM, so it takes the async reset too.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++)
                pc[i] <= '0;
            lock   <= '0;
            wr_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_hit[i])
                    pc[i] <= wr_data;
                else if (count_en)
                    pc[i] <= pc[i] + STEP;
            end
            lock   <= lock | lock_set;
            wr_err <= wr_rej;
        end
    end

    always_comb begin
        pc_out = '0;
        for (int i = 0; i < NUM_CH; i++)
            pc_out[i*DATA_W +: DATA_W] = pc[i];
    end

    assign lock_status    = lock;
    assign debug_unlocked = unlocked;

endmodule

// File: tb/tb_lock_pc_bank.sv
// Self-checking bench for lock_pc_bank: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model of the bank.
module tb_lock_pc_bank;

    localparam int          NUM_CH  = 4;
    localparam int          DATA_W  = 32;
    localparam int          INC     = 4;
    localparam int          DBG_WIN = 16;
    localparam logic [31:0] KEY     = 32'hA5A5_5A5A;
`ifdef LOCK_PC_BANK_DEBUG_UNLOCK_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

    logic                      clk;
    logic                      resetn;
    logic                      wr_ni;
    logic [1:0]                wr_ch;
    logic [DATA_W-1:0]         wr_data;
    logic [NUM_CH-1:0]         lock_set;
    logic                      count_en;
    logic                      scan;
    logic                      debug_req;
    logic [DATA_W-1:0]         debug_key;
    logic [NUM_CH*DATA_W-1:0]  pc_out;
    logic [NUM_CH-1:0]         lock_status;
    logic                      debug_unlocked;
    logic                      wr_err;

    lock_pc_bank #(
        .NUM_CH  (NUM_CH),
        .DATA_W  (DATA_W),
        .INC     (INC),
        .DBG_KEY (KEY),
        .DBG_WIN (DBG_WIN)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .wr_ni          (wr_ni),
        .wr_ch          (wr_ch),
        .wr_data        (wr_data),
        .lock_set       (lock_set),
        .count_en       (count_en),
        .scan           (scan),
        .debug_req      (debug_req),
        .debug_key      (debug_key),
        .pc_out         (pc_out),
        .lock_status    (lock_status),
        .debug_unlocked (debug_unlocked),
        .wr_err         (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: session tracked as remaining window / penalty cycles.
    logic [31:0]       m_pc [NUM_CH];
    logic [NUM_CH-1:0] m_lock;
    bit                m_err;
    bit                m_chk_pend;
    logic [31:0]       m_key;
    int                m_win_left;
    int                m_pen_left;
    bit                m_need_drop;

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) m_pc[i] = '0;
        m_lock      = '0;
        m_err       = 1'b0;
        m_chk_pend  = 1'b0;
        m_key       = '0;
        m_win_left  = 0;
        m_pen_left  = 0;
        m_need_drop = 1'b0;
    endtask

    task automatic model_step();
        bit unl;
        bit acc;
        unl = (m_win_left > 0);
        acc = !wr_ni && !scan && (int'(wr_ch) < NUM_CH) && (!m_lock[wr_ch] || unl);
        for (int i = 0; i < NUM_CH; i++) begin
            if (acc && i == int'(wr_ch)) m_pc[i] = wr_data;
            else if (count_en)           m_pc[i] = m_pc[i] + 32'(INC);
        end
        m_err  = !wr_ni && !acc;
        m_lock = m_lock | lock_set;
        if (DBG_EN) begin
            if (m_chk_pend) begin
                m_chk_pend = 1'b0;
                if (m_key == KEY) m_win_left = DBG_WIN;
                else              m_pen_left = DBG_WIN;
            end else if (m_win_left > 0) begin
                if (!debug_req) begin
                    m_win_left = 0;
                end else begin
                    m_win_left--;
                    if (m_win_left == 0) m_need_drop = 1'b1;
                end
            end else if (m_pen_left > 0) begin
                m_pen_left--;
            end else if (debug_req && !m_need_drop) begin
                m_chk_pend = 1'b1;
                m_key      = debug_key;
            end
            if (!debug_req) m_need_drop = 1'b0;
            if (scan) begin
                m_chk_pend = 1'b0;
                m_win_left = 0;
                m_pen_left = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        if (resetn) model_step();
    end

    always @(negedge clk) begin
        if (resetn) begin
            for (int i = 0; i < NUM_CH; i++)
                check($sformatf("pc%0d", i), pc_out[i*DATA_W +: DATA_W], m_pc[i]);
            check("lock_status", 32'(lock_status), 32'(m_lock));
            check("wr_err", 32'(wr_err), 32'(m_err));
            check("debug_unlocked", 32'(debug_unlocked), 32'(m_win_left > 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_ni     = 1'b1;
        wr_ch     = '0;
        wr_data   = '0;
        lock_set  = '0;
        count_en  = 1'b0;
        scan      = 1'b0;
        debug_req = 1'b0;
        debug_key = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < NUM_CH; i++)
            check("rst_pc", pc_out[i*DATA_W +: DATA_W], 32'h0);
        check("rst_lock", 32'(lock_status), 32'h0);
        check("rst_wr_err", 32'(wr_err), 32'h0);
        check("rst_unlocked", 32'(debug_unlocked), 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    logic [31:0] prev;

    initial begin
        resetn = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        do_reset();

        // Free-running increment from reset.
        count_en = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < NUM_CH; i++)
            check("s1_pc_after_3", pc_out[i*DATA_W +: DATA_W], 32'h0000_000C);

        // Write, lock, rejected rewrite.
        wr_ni = 1'b0; wr_ch = 2'd1; wr_data = 32'h100;
        tick();
        check("s2_write_ch1", pc_out[1*DATA_W +: DATA_W], 32'h100);
        wr_ni = 1'b1; lock_set = 4'b0010;
        tick();
        check("s2_lock_ch1", 32'(lock_status), 32'h2);
        lock_set = '0; wr_ni = 1'b0; wr_data = 32'h200;
        tick();
        check("s2_rej_err", 32'(wr_err), 32'h1);
        check("s2_rej_ch1", pc_out[1*DATA_W +: DATA_W], 32'h108);
        wr_ni = 1'b1;
        tick();
        check("s2_err_one_cycle", 32'(wr_err), 32'h0);
        check("s2_ch1_continues", pc_out[1*DATA_W +: DATA_W], 32'h10C);

        // Write in the same cycle as its lock request is still accepted.
        count_en = 1'b0;
        wr_ni = 1'b0; wr_ch = 2'd3; wr_data = 32'h300; lock_set = 4'b1000;
        tick();
        check("s2b_same_cycle_wr", pc_out[3*DATA_W +: DATA_W], 32'h300);
        check("s2b_same_cycle_err", 32'(wr_err), 32'h0);
        check("s2b_lock", 32'(lock_status), 32'hA);
        wr_ni = 1'b1; lock_set = '0;

        // Debug unlock with the correct key, write a locked channel, window expiry.
        lock_set = 4'b0100;
        tick();
        lock_set = '0;
        debug_req = 1'b1; debug_key = KEY;
        tick();
        debug_key = '0;
        tick();
        check("s3_unlocked", 32'(debug_unlocked), 32'(DBG_EN));
        prev = m_pc[2];
        wr_ni = 1'b0; wr_ch = 2'd2; wr_data = 32'h55;
        tick();
        wr_ni = 1'b1;
        check("s3_unlocked_wr", pc_out[2*DATA_W +: DATA_W], DBG_EN ? 32'h55 : prev);
        check("s3_unlocked_err", 32'(wr_err), 32'(!DBG_EN));
        repeat (14) tick();
        check("s3_win_last", 32'(debug_unlocked), 32'(DBG_EN));
        tick();
        check("s3_win_expired", 32'(debug_unlocked), 32'h0);
        debug_key = KEY;
        repeat (4) tick();
        check("s3_needs_rearm", 32'(debug_unlocked), 32'h0);
        debug_req = 1'b0;
        tick();

        // Wrong key then re-request inside the penalty.
        debug_req = 1'b1; debug_key = 32'h0;
        tick();
        tick();
        debug_req = 1'b0;
        tick();
        debug_req = 1'b1; debug_key = KEY;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("s4_penalty", 32'(debug_unlocked), 32'h0);
        end
        debug_req = 1'b0;
        repeat (20) tick();

        // Scan kills the session and rejects writes.
        debug_req = 1'b1; debug_key = KEY;
        tick();
        tick();
        check("s5_unlocked", 32'(debug_unlocked), 32'(DBG_EN));
        scan = 1'b1; wr_ni = 1'b0; wr_ch = 2'd0; wr_data = 32'h77;
        tick();
        check("s5_scan_unlock", 32'(debug_unlocked), 32'h0);
        check("s5_scan_err", 32'(wr_err), 32'h1);
        scan = 1'b0; wr_ni = 1'b1; debug_req = 1'b0;
        tick();
        check("s5_err_clear", 32'(wr_err), 32'h0);

        // Wrap-around and reset in the middle of a session.
        wr_ni = 1'b0; wr_ch = 2'd0; wr_data = 32'hFFFF_FFFC;
        tick();
        check("s6_write_max", pc_out[0 +: DATA_W], 32'hFFFF_FFFC);
        wr_ni = 1'b1; count_en = 1'b1;
        tick();
        check("s6_wrap", pc_out[0 +: DATA_W], 32'h0);
        count_en = 1'b0;
        debug_req = 1'b1; debug_key = KEY;
        tick();
        tick();
        tick();
        check("s6_unlocked", 32'(debug_unlocked), 32'(DBG_EN));
        do_reset();
        idle_inputs();
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            wr_ni    = ($urandom_range(0, 1) == 0);
            wr_ch    = 2'($urandom_range(0, 3));
            wr_data  = $urandom;
            for (int b = 0; b < NUM_CH; b++)
                lock_set[b] = ($urandom_range(0, 15) == 0);
            count_en = ($urandom_range(0, 3) != 0);
            scan     = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, ((n / 300) % 2 == 1) ? 40 : 6) == 0)
                debug_req = ~debug_req;
            debug_key = ($urandom_range(0, 1) == 0) ? KEY : $urandom;
            tick();
            if (n % 600 == 599) do_reset();
        end

        idle_inputs();
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lock_pc_bank.md
LOCK_PC_BANK -- requirements
Module: lock_pc_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent lockable counter channels.
REQ-002 SHALL have parameter DATA_W, default 32: channel register width.
REQ-003 SHALL have parameter INC, default 4: per-cycle auto-increment step.
REQ-004 SHALL have parameter DBG_KEY, default 32'hA5A5_5A5A: debug unlock key, truncated to DATA_W.
REQ-005 SHALL have parameter DBG_WIN, default 16: maximum unlocked cycles, also the penalty-wait cycles.
REQ-006 SHALL have ports, in order:
- clk  in  1  single clock.
- resetn  in  1  asynchronous active-low reset.
- wr_ni  in  1  active-low write strobe.
- wr_ch  in  $clog2(NUM_CH)  write channel select.
- wr_data  in  DATA_W  write data.
- lock_set  in  NUM_CH  per-channel lock request.
- count_en  in  1  global increment enable.
- scan  in  1  scan mode.
- debug_req  in  1  debug session request, level.
- debug_key  in  DATA_W  debug credential.
- pc_out  out  NUM_CH*DATA_W  channel registers, ch0 in LSBs.
- lock_status  out  NUM_CH  current lock bits.
- debug_unlocked  out  1  override active.
- wr_err  out  1  one-cycle rejected-write pulse.

Function
REQ-007 SHALL accept a write when wr_ni=0, wr_ch<NUM_CH, scan=0, and (lock[wr_ch]=0 or debug_unlocked=1); pc[wr_ch] SHALL take wr_data on the next edge.
REQ-008 SHALL, for each channel not written in a cycle, add INC to pc when count_en=1 and hold otherwise; the sum wraps modulo 2^DATA_W.
REQ-009 SHALL treat a rejected write (locked and not unlocked, scan=1, or wr_ch>=NUM_CH) as: register unchanged except for the REQ-008 increment, and wr_err=1 for exactly the following cycle.
REQ-010 SHALL set lock[i] on the edge after lock_set[i]=1; lock SHALL clear only by reset.
REQ-011 SHALL evaluate a write in the same cycle as lock_set on that channel against the pre-edge lock value, so the write is accepted.
REQ-012 SHALL implement the debug FSM with states IDLE, CHECK, UNLOCKED, PENALTY:
- IDLE -> CHECK on debug_req=1; debug_key is registered on that edge.
- CHECK -> UNLOCKED if the registered key equals DBG_KEY, else -> PENALTY.
- UNLOCKED -> IDLE when debug_req=0, or after DBG_WIN cycles in UNLOCKED.
- PENALTY -> IDLE after DBG_WIN cycles; debug_req is ignored during PENALTY.
REQ-013 SHALL drive debug_unlocked=1 only in state UNLOCKED.
REQ-014 SHALL force the FSM to IDLE on the edge where scan=1, from any state; the FSM SHALL stay in IDLE while scan=1.
REQ-015 SHALL, in UNLOCKED with debug_req still high at window expiry, return to IDLE and require debug_req to drop and re-rise before entering CHECK again.

Reset
REQ-016 SHALL, on resetn=0 at any time including mid-session, asynchronously set:
- all pc registers to 0;
- all lock bits to 0;
- the FSM to IDLE;
- window/penalty counters to 0;
- wr_err to 0 and debug_unlocked to 0.
REQ-017 SHALL give the first post-reset edge normal REQ-007/REQ-008 behaviour.

Configuration
REQ-018 SHALL use macro LOCK_PC_BANK_DEBUG_UNLOCK_EN:
- Defined: the debug FSM (REQ-012 to REQ-015) is present.
- Undefined: no FSM, debug_unlocked is tied to 0, debug_req and debug_key are ignored, and locked channels are never writable after lock.

Structure
REQ-019 SHALL place the FSM state enum, the default DBG_KEY, and the default DBG_WIN in shared package lock_pc_bank_pkg.
REQ-020 SHALL implement the debug FSM and its window/penalty counter in sub-module lock_dbg_auth, instantiated only under LOCK_PC_BANK_DEBUG_UNLOCK_EN.

Verification
REQ-021 SHALL cover these directed scenarios (default parameters):
- Reset, count_en=1, 3 cycles -> every channel reads 0x0000000C.
- Write ch1=0x100, lock_set[1], then write ch1=0x200 -> ch1 continues from 0x100 plus increments; wr_err pulses once.
- Lock ch2; debug_req with key 0xA5A55A5A; write ch2=0x55 while unlocked -> ch2=0x55; after DBG_WIN cycles debug_unlocked=0.
- Wrong key 0x0 -> PENALTY; re-request inside 16 cycles -> debug_unlocked stays 0.
- Unlocked, then scan=1 -> debug_unlocked=0 next cycle; writes during scan -> wr_err.
- ch0=0xFFFFFFFC, count_en=1 -> next value 0x00000000; resetn low mid-UNLOCKED -> all outputs 0 immediately.
